// File: rtl/tl_ul_pkg.sv
// rtl/tl_ul_pkg.sv - TileLink-UL field widths, opcode constants and channel structs
//
// Shared by tl_source_shrinker and tl_slot_alloc.
// No ports; import with "import tl_ul_pkg::*;".

package tl_ul_pkg;

  localparam int SRC_W     = 5;
  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int MASK_W    = 4;
  localparam int OPC_W     = 3;
  localparam int A_PARAM_W = 3;
  localparam int D_PARAM_W = 2;
  localparam int SIZE_W    = 2;

  // A-channel opcodes
  localparam logic [OPC_W-1:0] OP_PUT_FULL    = 3'd0;
  localparam logic [OPC_W-1:0] OP_PUT_PARTIAL = 3'd1;
  localparam logic [OPC_W-1:0] OP_GET         = 3'd4;

  // D-channel opcodes
  localparam logic [OPC_W-1:0] OP_ACCESS_ACK      = 3'd0;
  localparam logic [OPC_W-1:0] OP_ACCESS_ACK_DATA = 3'd1;

  // Largest legal transfer on a 32-bit bus is 4 bytes (log2 = 2).
  localparam logic [SIZE_W-1:0] MAX_SIZE = 2'd2;

  typedef struct packed {
    logic [OPC_W-1:0]     opcode;
    logic [A_PARAM_W-1:0] param;
    logic [SIZE_W-1:0]    size;
    logic [SRC_W-1:0]     source;
    logic [ADDR_W-1:0]    address;
    logic [MASK_W-1:0]    mask;
    logic [DATA_W-1:0]    data;
    logic                 corrupt;
  } tl_a_t;

  typedef struct packed {
    logic [OPC_W-1:0]     opcode;
    logic [D_PARAM_W-1:0] param;
    logic [SIZE_W-1:0]    size;
    logic [SRC_W-1:0]     source;
    logic                 sink;
    logic                 denied;
    logic [DATA_W-1:0]    data;
    logic                 corrupt;
  } tl_d_t;

endpackage

// File: rtl/tl_slot_alloc.sv
// rtl/tl_slot_alloc.sv - lowest-free-slot priority encoder with full flag
//
// Ports:
//   slot_vld_i  in   SLOTS      per-slot busy bits
//   alloc_o     out  SLOT_BITS  lowest index whose busy bit is clear (0 when full)
//   full_o      out  1          every slot busy

module tl_slot_alloc
  import tl_ul_pkg::*;
#(
  parameter int SLOT_BITS = 2
) (
  input  logic [(1<<SLOT_BITS)-1:0] slot_vld_i,
  output logic [SLOT_BITS-1:0]      alloc_o,
  output logic                      full_o
);

  localparam int SLOTS = 1 << SLOT_BITS;

  assign full_o = &slot_vld_i;

  // Scan from the top down so the last hit is the lowest free index.
  always_comb begin
    alloc_o = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (!slot_vld_i[i]) begin
        alloc_o = i[SLOT_BITS-1:0];
      end
    end
  end

endmodule

// File: rtl/tl_source_shrinker.sv
// rtl/tl_source_shrinker.sv - TL-UL source-ID compressor with in-flight slot tracking
//
// Maps the 5-bit upstream A source onto SLOTS downstream slots and restores
// it on D. A and D pass through combinationally; A stalls while all slots
// are busy.
//
// Optional feature macro: TL_SHRINK_ERR_EN (sticky protocol error flag).
//
// Ports:
//   clock, reset_n           clock, asynchronous active-low reset
//   in_a_*  / in_a_ready     upstream A (in), ready (out)
//   out_a_* / out_a_ready    downstream A (out), ready (in); source is SLOT_BITS wide
//   out_d_* / out_d_ready    downstream D (in), ready (out); source is SLOT_BITS wide
//   in_d_*  / in_d_ready     upstream D (out), ready (in); source restored to 5 bits
//   idle                     no request in flight
//   err                      sticky protocol error (0 unless TL_SHRINK_ERR_EN)

module tl_source_shrinker
  import tl_ul_pkg::*;
#(
  parameter int SLOT_BITS = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  // upstream A
  input  logic                  in_a_valid,
  output logic                  in_a_ready,
  input  logic [OPC_W-1:0]      in_a_opcode,
  input  logic [A_PARAM_W-1:0]  in_a_param,
  input  logic [SIZE_W-1:0]     in_a_size,
  input  logic [SRC_W-1:0]      in_a_source,
  input  logic [ADDR_W-1:0]     in_a_address,
  input  logic [MASK_W-1:0]     in_a_mask,
  input  logic [DATA_W-1:0]     in_a_data,
  input  logic                  in_a_corrupt,
  // downstream A
  output logic                  out_a_valid,
  input  logic                  out_a_ready,
  output logic [OPC_W-1:0]      out_a_opcode,
  output logic [A_PARAM_W-1:0]  out_a_param,
  output logic [SIZE_W-1:0]     out_a_size,
  output logic [SLOT_BITS-1:0]  out_a_source,
  output logic [ADDR_W-1:0]     out_a_address,
  output logic [MASK_W-1:0]     out_a_mask,
  output logic [DATA_W-1:0]     out_a_data,
  output logic                  out_a_corrupt,
  // downstream D
  input  logic                  out_d_valid,
  output logic                  out_d_ready,
  input  logic [OPC_W-1:0]      out_d_opcode,
  input  logic [D_PARAM_W-1:0]  out_d_param,
  input  logic [SIZE_W-1:0]     out_d_size,
  input  logic [SLOT_BITS-1:0]  out_d_source,
  input  logic                  out_d_sink,
  input  logic                  out_d_denied,
  input  logic                  out_d_corrupt,
  input  logic [DATA_W-1:0]     out_d_data,
  // upstream D
  output logic                  in_d_valid,
  input  logic                  in_d_ready,
  output logic [OPC_W-1:0]      in_d_opcode,
  output logic [D_PARAM_W-1:0]  in_d_param,
  output logic [SIZE_W-1:0]     in_d_size,
  output logic [SRC_W-1:0]      in_d_source,
  output logic                  in_d_sink,
  output logic                  in_d_denied,
  output logic                  in_d_corrupt,
  output logic [DATA_W-1:0]     in_d_data,
  // status
  output logic                  idle,
  output logic                  err
);

  localparam int SLOTS = 1 << SLOT_BITS;

  logic [SLOTS-1:0]     slot_vld_q, slot_vld_d;
  logic [SRC_W-1:0]     slot_src_q [SLOTS];
  logic [SRC_W-1:0]     slot_src_d [SLOTS];
  logic [SLOT_BITS-1:0] alloc;
  logic                 full;
  logic                 a_fire, d_fire;
  tl_a_t                a_req;
  tl_d_t                d_rsp;

  // alloc/full come from registered state only, so a slot freed this cycle
  // becomes available next cycle and ready never depends on same-cycle valid.
  tl_slot_alloc #(
    .SLOT_BITS (SLOT_BITS)
  ) u_slot_alloc (
    .slot_vld_i (slot_vld_q),
    .alloc_o    (alloc),
    .full_o     (full)
  );

  // ---------------- A path ----------------
  assign a_req = '{
    opcode:  in_a_opcode,
    param:   in_a_param,
    size:    in_a_size,
    source:  in_a_source,
    address: in_a_address,
    mask:    in_a_mask,
    data:    in_a_data,
    corrupt: in_a_corrupt
  };

  assign out_a_valid   = in_a_valid & ~full;
  assign in_a_ready    = out_a_ready & ~full;
  assign out_a_opcode  = a_req.opcode;
  assign out_a_param   = a_req.param;
  assign out_a_size    = a_req.size;
  assign out_a_source  = alloc;
  assign out_a_address = a_req.address;
  assign out_a_mask    = a_req.mask;
  assign out_a_data    = a_req.data;
  assign out_a_corrupt = a_req.corrupt;

  assign a_fire = in_a_valid & in_a_ready;

  // ---------------- D path ----------------
  assign d_rsp = '{
    opcode:  out_d_opcode,
    param:   out_d_param,
    size:    out_d_size,
    source:  slot_src_q[out_d_source],
    sink:    out_d_sink,
    denied:  out_d_denied,
    data:    out_d_data,
    corrupt: out_d_corrupt
  };

  assign in_d_valid   = out_d_valid;
  assign out_d_ready  = in_d_ready;
  assign in_d_opcode  = d_rsp.opcode;
  assign in_d_param   = d_rsp.param;
  assign in_d_size    = d_rsp.size;
  assign in_d_source  = d_rsp.source;
  assign in_d_sink    = d_rsp.sink;
  assign in_d_denied  = d_rsp.denied;
  assign in_d_corrupt = d_rsp.corrupt;
  assign in_d_data    = d_rsp.data;

  assign d_fire = out_d_valid & out_d_ready;

  // ---------------- slot table ----------------
  // Apply the D clear before the A set: a D to an unallocated slot that
  // happens to equal alloc must not cancel the new allocation.
  always_comb begin
    slot_vld_d = slot_vld_q;
    slot_src_d = slot_src_q;
    if (d_fire) begin
      slot_vld_d[out_d_source] = 1'b0;
    end
    if (a_fire) begin
      slot_vld_d[alloc] = 1'b1;
      slot_src_d[alloc] = a_req.source;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      slot_vld_q <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        slot_src_q[i] <= '0;
      end
    end else begin
      slot_vld_q <= slot_vld_d;
      slot_src_q <= slot_src_d;
    end
  end

  assign idle = ~|slot_vld_q;

  // ---------------- error flag ----------------
`ifdef TL_SHRINK_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (d_fire && !slot_vld_q[out_d_source]) begin
      err_d = 1'b1;
    end
    if (a_fire && (a_req.size > MAX_SIZE)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
